// File: rtl/regfile.sv
// RV32 integer register file: 32 x 32-bit, two combinational read ports, one
// synchronous write port, x0 hardwired to zero, optional write-to-read bypass.
module regfile #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);

    localparam int unsigned N_ENTRIES = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [N_ENTRIES];
    logic              w_wr_valid;
    logic              w_hit1;
    logic              w_hit2;

    // Entry 0 is never written, so it holds the reset value of zero forever.
    assign w_wr_valid = rst && wen && (waddr != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(N_ENTRIES); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_valid) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Bypass hits are qualified by w_wr_valid, so x0 and reset never forward.
    assign w_hit1 = (BYPASS != 0) && w_wr_valid && (waddr == raddr1);
    assign w_hit2 = (BYPASS != 0) && w_wr_valid && (waddr == raddr2);

    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (raddr1 != '0) begin
            rdata1 = w_hit1 ? wdata : r_mem[raddr1];
        end
        if (raddr2 != '0) begin
            rdata2 = w_hit2 ? wdata : r_mem[raddr2];
        end
    end

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile; runs a bypassing and a
// non-bypassing instance side by side on the same stimulus.
module tb_regfile;

    logic        clk;
    logic        rst;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;

    int checks   = 0;
    int failures = 0;

    regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) u_dut_b (
        .clk(clk), .rst(rst), .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rd1_b), .rdata2(rd2_b),
        .wen(wen), .waddr(waddr), .wdata(wdata)
    );

    regfile #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) u_dut_n (
        .clk(clk), .rst(rst), .raddr1(raddr1), .raddr2(raddr2),
        .rdata1(rd1_n), .rdata2(rd2_n),
        .wen(wen), .waddr(waddr), .wdata(wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        wen   = 1'b1;
        waddr = a;
        wdata = d;
        @(posedge clk);
        #1;
        wen = 1'b0;
    endtask

    initial begin
        rst    = 1'b0;
        wen    = 1'b1;
        waddr  = 5'd1;
        wdata  = 32'h1234_5678;
        raddr1 = 5'd1;
        raddr2 = 5'd2;

        // Reset held with an active write
        repeat (5) @(posedge clk);
        #1;
        check("rst_hold_rd1_b", rd1_b, 32'h0);
        check("rst_hold_rd1_n", rd1_n, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        wen = 1'b0;
        #1;
        check("rst_rel_rd1_b", rd1_b, 32'h0);
        check("rst_rel_rd2_b", rd2_b, 32'h0);
        check("rst_rel_rd1_n", rd1_n, 32'h0);
        check("rst_rel_rd2_n", rd2_n, 32'h0);

        // x0 write is discarded and never bypassed
        @(negedge clk);
        wen    = 1'b1;
        waddr  = 5'd0;
        wdata  = 32'hb105_f00d;
        raddr1 = 5'd0;
        #1;
        check("x0_pre_b", rd1_b, 32'h0);
        check("x0_pre_n", rd1_n, 32'h0);
        @(posedge clk);
        #1;
        wen = 1'b0;
        check("x0_post_b", rd1_b, 32'h0);
        check("x0_post_n", rd1_n, 32'h0);

        // Writes and overwrite
        do_write(5'd1, 32'hdead_beef);
        raddr2 = 5'd1;
        #1;
        check("x1_first_n", rd2_n, 32'hdead_beef);
        do_write(5'd1, 32'h8bad_f00d);
        do_write(5'd2, 32'hbaad_cafe);
        do_write(5'd3, 32'hcafe_d00d);
        raddr1 = 5'd0;
        raddr2 = 5'd1;
        #1;
        check("rd_0_b", rd1_b, 32'h0);
        check("rd_x1_b", rd2_b, 32'h8bad_f00d);
        check("rd_x1_n", rd2_n, 32'h8bad_f00d);
        raddr1 = 5'd2;
        raddr2 = 5'd3;
        #1;
        check("rd_x2_b", rd1_b, 32'hbaad_cafe);
        check("rd_x3_b", rd2_b, 32'hcafe_d00d);
        check("rd_x2_n", rd1_n, 32'hbaad_cafe);
        check("rd_x3_n", rd2_n, 32'hcafe_d00d);
        raddr1 = 5'd3;
        raddr2 = 5'd3;
        #1;
        check("same_addr_b", rd1_b, rd2_b);
        check("same_addr_val", rd1_b, 32'hcafe_d00d);

        // Mid-run asynchronous reset, not aligned to a clock edge
        @(negedge clk);
        #2;
        rst = 1'b0;
        raddr1 = 5'd1;
        raddr2 = 5'd2;
        #1;
        check("mid_rst_x1_b", rd1_b, 32'h0);
        check("mid_rst_x2_b", rd2_b, 32'h0);
        check("mid_rst_x1_n", rd1_n, 32'h0);
        raddr1 = 5'd3;
        #1;
        check("mid_rst_x3_b", rd1_b, 32'h0);
        #8;
        rst = 1'b1;
        #1;
        check("post_rst_x3_b", rd1_b, 32'h0);
        check("post_rst_x2_n", rd2_n, 32'h0);
        raddr1 = 5'd1;
        #1;
        check("post_rst_x1_b", rd1_b, 32'h0);

        // Bypass versus stored value
        do_write(5'd5, 32'h1111_1111);
        @(negedge clk);
        wen    = 1'b1;
        waddr  = 5'd5;
        wdata  = 32'h2222_2222;
        raddr1 = 5'd5;
        raddr2 = 5'd5;
        #1;
        check("byp_pre_rd1_b", rd1_b, 32'h2222_2222);
        check("byp_pre_rd2_b", rd2_b, 32'h2222_2222);
        check("byp_pre_rd1_n", rd1_n, 32'h1111_1111);
        check("byp_pre_rd2_n", rd2_n, 32'h1111_1111);
        @(posedge clk);
        #1;
        check("byp_post_rd1_b", rd1_b, 32'h2222_2222);
        check("byp_post_rd1_n", rd1_n, 32'h2222_2222);
        check("byp_post_rd2_n", rd2_n, 32'h2222_2222);

        // Independent bypass per port
        @(negedge clk);
        waddr  = 5'd6;
        wdata  = 32'h3333_3333;
        raddr1 = 5'd5;
        raddr2 = 5'd6;
        #1;
        check("byp_ind_rd1_b", rd1_b, 32'h2222_2222);
        check("byp_ind_rd2_b", rd2_b, 32'h3333_3333);
        check("byp_ind_rd2_n", rd2_n, 32'h0);
        @(posedge clk);
        #1;
        wen = 1'b0;
        check("byp_ind_post_n", rd2_n, 32'h3333_3333);

        // wen gating
        @(negedge clk);
        wen    = 1'b0;
        waddr  = 5'd7;
        wdata  = 32'hffff_ffff;
        raddr1 = 5'd7;
        #1;
        check("wen0_pre_b", rd1_b, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("wen0_x7_b", rd1_b, 32'h0);
        check("wen0_x7_n", rd1_n, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
